// File: rtl/ping_pong_pkg.sv
// Shared ping-pong types and constants: paddle direction encoding, speed defaults
// and source slot indices.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  localparam int unsigned DEF_SPEED_W   = 3;
  localparam int unsigned DEF_MAX_SPEED = 4;

  localparam int unsigned SRC_BTN = 0;
  localparam int unsigned SRC_KEY = 1;

endpackage

// File: rtl/paddle_ch_state.sv
// One paddle channel: pending up/down requests, per-frame direction state,
// hold-frame counter, speed and sticky conflict flag.
module paddle_ch_state
  import ping_pong_pkg::*;
#(
  parameter int unsigned SPEED_W      = DEF_SPEED_W,
  parameter int unsigned MAX_SPEED    = DEF_MAX_SPEED,
  parameter int unsigned ACCEL_FRAMES = 8,
  parameter int unsigned HOLD_W       = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               up_req,
  input  logic               down_req,
  input  logic               accel_en,
  output logic               cmd_up,
  output logic               cmd_down,
  output logic [SPEED_W-1:0] cmd_speed,
  output logic               conflict
);

  localparam logic [SPEED_W-1:0] STEP_MAX = SPEED_W'(MAX_SPEED - 1);
  localparam bit ACCEL_POW2 = ((ACCEL_FRAMES & (ACCEL_FRAMES - 1)) == 0);

  logic               up_pend_q, up_pend_d;
  logic               down_pend_q, down_pend_d;
  dir_t               dir_q, dir_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               cmd_up_q, cmd_up_d;
  logic               cmd_down_q, cmd_down_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               conflict_q, conflict_d;
  logic               snap_up, snap_down;
  dir_t               new_dir;
  logic               hold_inc, hold_clr;
  logic [SPEED_W-1:0] steps_d;

  always_comb begin
    snap_up     = up_pend_q | up_req;
    snap_down   = down_pend_q | down_req;
    up_pend_d   = snap_up;
    down_pend_d = snap_down;
    dir_d       = dir_q;
    hold_d      = hold_q;
    cmd_up_d    = cmd_up_q;
    cmd_down_d  = cmd_down_q;
    conflict_d  = conflict_q;
    hold_inc    = 1'b0;
    hold_clr    = 1'b0;
    new_dir     = DIR_IDLE;
    if (frame_start) begin
      up_pend_d   = 1'b0;
      down_pend_d = 1'b0;
      if (snap_up && !snap_down)      new_dir = DIR_UP;
      else if (snap_down && !snap_up) new_dir = DIR_DOWN;
      if (snap_up && snap_down) conflict_d = 1'b1;
      if (new_dir != DIR_IDLE && new_dir == dir_q) begin
        if (hold_q != '1) begin
          hold_d   = hold_q + 1'b1;
          hold_inc = 1'b1;
        end
      end else begin
        hold_d   = '0;
        hold_clr = 1'b1;
      end
      dir_d      = new_dir;
      cmd_up_d   = (new_dir == DIR_UP);
      cmd_down_d = (new_dir == DIR_DOWN);
    end
  end

  // steps_d = min(hold_d / ACCEL_FRAMES, MAX_SPEED-1); the sub-counter path
  // tracks the quotient incrementally so no divider is needed.
  generate
    if (ACCEL_POW2) begin : g_shift
      localparam int unsigned SHIFT = $clog2(ACCEL_FRAMES);
      logic [HOLD_W-1:0] quot;
      always_comb begin
        quot    = hold_d >> SHIFT;
        steps_d = (32'(quot) >= MAX_SPEED - 1) ? STEP_MAX : SPEED_W'(quot);
      end
    end else begin : g_subcnt
      logic [HOLD_W-1:0]  sub_q, sub_d;
      logic [SPEED_W-1:0] step_q;
      always_comb begin
        sub_d   = sub_q;
        steps_d = step_q;
        if (hold_clr) begin
          sub_d   = '0;
          steps_d = '0;
        end else if (hold_inc) begin
          if (32'(sub_q) == ACCEL_FRAMES - 1) begin
            sub_d = '0;
            if (step_q != STEP_MAX) steps_d = step_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sub_q  <= '0;
          step_q <= '0;
        end else begin
          sub_q  <= sub_d;
          step_q <= steps_d;
        end
      end
    end
  endgenerate

  always_comb begin
    speed_d = speed_q;
    if (frame_start) begin
      if (dir_d == DIR_IDLE) speed_d = '0;
      else if (!accel_en)    speed_d = SPEED_W'(1);
      else                   speed_d = steps_d + SPEED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_pend_q   <= 1'b0;
      down_pend_q <= 1'b0;
      dir_q       <= DIR_IDLE;
      hold_q      <= '0;
      cmd_up_q    <= 1'b0;
      cmd_down_q  <= 1'b0;
      speed_q     <= '0;
      conflict_q  <= 1'b0;
    end else begin
      up_pend_q   <= up_pend_d;
      down_pend_q <= down_pend_d;
      dir_q       <= dir_d;
      hold_q      <= hold_d;
      cmd_up_q    <= cmd_up_d;
      cmd_down_q  <= cmd_down_d;
      speed_q     <= speed_d;
      conflict_q  <= conflict_d;
    end
  end

  assign cmd_up    = cmd_up_q;
  assign cmd_down  = cmd_down_q;
  assign cmd_speed = speed_q;
  assign conflict  = conflict_q;

endmodule

// File: rtl/paddle_cmd_latch.sv
// Per-frame paddle command latch: merges masked request sources per channel and
// snapshots them on frame_start into registered commands.
module paddle_cmd_latch
  import ping_pong_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned SPEED_W      = DEF_SPEED_W,
  parameter int unsigned MAX_SPEED    = DEF_MAX_SPEED,
  parameter int unsigned ACCEL_FRAMES = 8,
  parameter int unsigned HOLD_W       = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic [NUM_CH*NUM_SRC-1:0] src_up,
  input  logic [NUM_CH*NUM_SRC-1:0] src_down,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic                      accel_en,
  output logic [NUM_CH-1:0]         cmd_up,
  output logic [NUM_CH-1:0]         cmd_down,
  output logic [NUM_CH*SPEED_W-1:0] cmd_speed,
  output logic                      cmd_valid,
  output logic [NUM_CH-1:0]         conflict
);

  logic [NUM_CH-1:0] up_req, down_req;
  logic              cmd_valid_q, cmd_valid_d;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign up_req[c]   = |(src_up[c*NUM_SRC +: NUM_SRC] & src_mask);
      assign down_req[c] = |(src_down[c*NUM_SRC +: NUM_SRC] & src_mask);

      paddle_ch_state #(
        .SPEED_W      (SPEED_W),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES),
        .HOLD_W       (HOLD_W)
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .up_req      (up_req[c]),
        .down_req    (down_req[c]),
        .accel_en    (accel_en),
        .cmd_up      (cmd_up[c]),
        .cmd_down    (cmd_down[c]),
        .cmd_speed   (cmd_speed[c*SPEED_W +: SPEED_W]),
        .conflict    (conflict[c])
      );
    end
  endgenerate

  always_comb cmd_valid_d = frame_start;

  always_ff @(posedge clk) begin
    if (!rst_n) cmd_valid_q <= 1'b0;
    else        cmd_valid_q <= cmd_valid_d;
  end

  assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_paddle_cmd_latch.sv
// Bench for paddle_cmd_latch: frame-level reference model compared every cycle,
// plus literal expectations at key points of the directed scenarios.
module tb_paddle_cmd_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [3:0] src_up, src_down;
  logic [1:0] src_mask;
  logic       accel_en;
  logic [1:0] cmd_up, cmd_down, conflict;
  logic [5:0] cmd_speed;
  logic       cmd_valid;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  paddle_cmd_latch #(
    .NUM_CH       (2),
    .NUM_SRC      (2),
    .SPEED_W      (3),
    .MAX_SPEED    (4),
    .ACCEL_FRAMES (8),
    .HOLD_W       (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .src_up      (src_up),
    .src_down    (src_down),
    .src_mask    (src_mask),
    .accel_en    (accel_en),
    .cmd_up      (cmd_up),
    .cmd_down    (cmd_down),
    .cmd_speed   (cmd_speed),
    .cmd_valid   (cmd_valid),
    .conflict    (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view tracking consecutive same-direction frames.
  bit         m_pu[2], m_pd[2];
  int         m_dir[2];
  int         m_run[2];
  logic [1:0] e_up = '0, e_down = '0, e_conf = '0;
  logic [5:0] e_speed = '0;
  logic       e_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_pu[c] = 0; m_pd[c] = 0; m_dir[c] = 0; m_run[c] = 0;
      end
      e_up = '0; e_down = '0; e_conf = '0; e_speed = '0; e_valid = 1'b0;
    end else begin
      e_valid = frame_start;
      for (int c = 0; c < 2; c++) begin
        bit ru, rd, u, d;
        int dir, hold, spd;
        ru = 0; rd = 0;
        for (int s = 0; s < 2; s++) begin
          if (src_mask[s] && src_up[c*2+s])   ru = 1;
          if (src_mask[s] && src_down[c*2+s]) rd = 1;
        end
        if (frame_start) begin
          u = m_pu[c] || ru;
          d = m_pd[c] || rd;
          dir = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
          if (u && d) e_conf[c] = 1'b1;
          if (dir != 0 && dir == m_dir[c]) m_run[c]++;
          else m_run[c] = (dir != 0) ? 1 : 0;
          hold = (m_run[c] - 1 > 63) ? 63 : m_run[c] - 1;
          if (dir == 0)       spd = 0;
          else if (!accel_en) spd = 1;
          else                spd = (1 + hold / 8 > 4) ? 4 : 1 + hold / 8;
          e_up[c]          = (dir == 1);
          e_down[c]        = (dir == 2);
          e_speed[c*3 +: 3] = 3'(spd);
          m_dir[c] = dir;
          m_pu[c]  = 0;
          m_pd[c]  = 0;
        end else begin
          m_pu[c] = m_pu[c] || ru;
          m_pd[c] = m_pd[c] || rd;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_cmd_up", 32'(cmd_up), 32'(e_up));
      chk("model_cmd_down", 32'(cmd_down), 32'(e_down));
      chk("model_cmd_speed", 32'(cmd_speed), 32'(e_speed));
      chk("model_cmd_valid", 32'(cmd_valid), 32'(e_valid));
      chk("model_conflict", 32'(conflict), 32'(e_conf));
    end
  end

  task automatic pulse(input logic [3:0] u, input logic [3:0] d);
    src_up = u; src_down = d;
    @(negedge clk);
    src_up = '0; src_down = '0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b1; src_up = '1; src_down = 4'b0101;
    src_mask = 2'b11; accel_en = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_up", 32'(cmd_up), 32'd0);
    chk("rst_cmd_down", 32'(cmd_down), 32'd0);
    chk("rst_speed", 32'(cmd_speed), 32'd0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    frame_start = 1'b0; src_up = '0; src_down = '0; rst_n = 1'b1;

    // Single frame: ch0 btn up, snapshot ten cycles later
    repeat (5) @(negedge clk);
    pulse(4'b0001, 4'b0000);
    repeat (9) @(negedge clk);
    do_frame();
    chk("single_up", 32'(cmd_up), 32'd1);
    chk("single_down", 32'(cmd_down), 32'd0);
    chk("single_speed", 32'(cmd_speed), 32'd1);
    chk("single_valid", 32'(cmd_valid), 32'd1);
    @(negedge clk);
    chk("single_valid_drop", 32'(cmd_valid), 32'd0);
    chk("single_hold", 32'(cmd_up), 32'd1);
    do_frame();
    chk("empty_up", 32'(cmd_up), 32'd0);
    chk("empty_speed", 32'(cmd_speed), 32'd0);

    // Conflict on ch1: key up + btn down in one frame
    pulse(4'b1000, 4'b0100);
    repeat (2) @(negedge clk);
    do_frame();
    chk("conf_up", 32'(cmd_up), 32'd0);
    chk("conf_down", 32'(cmd_down), 32'd0);
    chk("conf_flag", 32'(conflict), 32'd2);
    do_frame();
    do_frame();
    chk("conf_sticky", 32'(conflict), 32'd2);

    // Acceleration on ch0 over 40 held frames, then reversal
    accel_en = 1'b1;
    for (int f = 1; f <= 40; f++) begin
      int es;
      pulse(4'b0001, 4'b0000);
      @(negedge clk);
      do_frame();
      case (f)
        1, 8:   es = 1;
        9, 16:  es = 2;
        17, 24: es = 3;
        25, 40: es = 4;
        default: es = 0;
      endcase
      if (es != 0) chk($sformatf("accel_f%0d", f), 32'(cmd_speed[2:0]), 32'(es));
    end
    pulse(4'b0000, 4'b0001);
    do_frame();
    chk("reverse_down", 32'(cmd_down), 32'd1);
    chk("reverse_speed", 32'(cmd_speed[2:0]), 32'd1);
    pulse(4'b0000, 4'b0001);
    accel_en = 1'b0;
    do_frame();
    chk("legacy_speed", 32'(cmd_speed[2:0]), 32'd1);

    // Masking and coincidence with frame_start
    src_mask = 2'b10;
    pulse(4'b0001, 4'b0000);
    do_frame();
    chk("mask_up", 32'(cmd_up), 32'd0);
    src_up = 4'b0010; frame_start = 1'b1;
    @(negedge clk);
    src_up = '0; frame_start = 1'b0;
    chk("coinc_up", 32'(cmd_up), 32'd1);
    do_frame();
    chk("coinc_next", 32'(cmd_up), 32'd0);

    // Back-to-back snapshots: second one sees only its own cycle
    pulse(4'b0010, 4'b0000);
    frame_start = 1'b1;
    @(negedge clk);
    src_down = 4'b0010;
    @(negedge clk);
    frame_start = 1'b0; src_down = '0;
    chk("b2b_down", 32'(cmd_down), 32'd1);
    chk("b2b_up", 32'(cmd_up), 32'd0);
    src_mask = 2'b11;

    // Reset mid-frame discards pending request and the frame pulse
    pulse(4'b0001, 4'b0000);
    rst_n = 1'b0; frame_start = 1'b1;
    repeat (2) @(negedge clk);
    frame_start = 1'b0;
    chk("midrst_conflict", 32'(conflict), 32'd0);
    chk("midrst_valid", 32'(cmd_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_frame();
    chk("midrst_up", 32'(cmd_up), 32'd0);
    chk("midrst_valid_after", 32'(cmd_valid), 32'd1);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
